// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one DMEM port between the CPU (fixed priority) and a DMA requester,
// with a starvation-forced DMA grant and per-owner routing of one-cycle read data.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_req,
  input  logic [3:0]        dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic {NORMAL, FORCE} state_t;
  typedef enum logic [1:0] {NONE, CPU, DMA} owner_t;
  localparam logic [7:0] MAX = 8'(MAX_WAIT);
  state_t state, state_nx;
  owner_t rd_owner, owner_nx;
  logic [7:0] wait_cnt, cnt_nx;
  logic cpu_gnt, dma_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORMAL;
      wait_cnt <= '0;
      rd_owner <= NONE;
    end else begin
      state    <= state_nx;
      wait_cnt <= cnt_nx;
      rd_owner <= owner_nx;
    end
  end
  always_comb begin
    dma_gnt   = dma_req && (state == FORCE || !cpu_req);
    cpu_gnt   = cpu_req && !dma_gnt;
    cpu_stall = cpu_req && !cpu_gnt;
    mem_en    = cpu_gnt || dma_gnt;
    mem_we    = cpu_gnt ? cpu_we    : dma_gnt ? dma_we    : '0;
    mem_addr  = cpu_gnt ? cpu_addr  : dma_gnt ? dma_addr  : '0;
    mem_wdata = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : '0;
    owner_nx  = (cpu_gnt && cpu_we == 4'd0) ? CPU : (dma_gnt && dma_we == 4'd0) ? DMA : NONE;
    dma_done  = dma_gnt || !dma_req;
    cnt_nx    = dma_done ? 8'd0 : (wait_cnt == MAX) ? MAX : wait_cnt + 8'd1;
    // Force one DMA grant on the cycle after its MAX_WAIT-th denial
    state_nx  = (state == NORMAL) ? ((!dma_done && wait_cnt == MAX - 8'd1) ? FORCE : NORMAL)
                                  : (dma_done ? NORMAL : FORCE);
    cpu_rvalid = rd_owner == CPU;
    dma_rvalid = rd_owner == DMA;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dma_rdata  = dma_rvalid ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench with a behavioural DMEM and a reference arbiter model.
module tb_dmem_port_arbiter;
  localparam int AW = 14;
  localparam int MW = 4;
  logic clk = 0, rst_n = 1;
  logic cpu_req = 0, dma_req = 0;
  logic [3:0] cpu_we = 0, dma_we = 0;
  logic [AW-1:0] cpu_addr = 0, dma_addr = 0;
  logic [31:0] cpu_wdata = 0, dma_wdata = 0;
  logic cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_en;
  logic [31:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem [0:255];
  logic [31:0] exp_mem [0:255];
  typedef struct {logic [1:0] own; logic [31:0] data;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  bit m_force = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = we[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we != 4'd0) mem[mem_addr[7:0]] <= merge(mem[mem_addr[7:0]], mem_wdata, mem_we);
    mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic cr, input logic [3:0] cwe, input logic [7:0] ca, input logic [31:0] cwd,
                      input logic dr, input logic [3:0] dwe, input logic [7:0] da, input logic [31:0] dwd,
                      input bit pulse = 0);
    logic eg_c, eg_d;
    exp_t e;
    cpu_req = cr; cpu_we = cwe; cpu_addr = AW'(ca); cpu_wdata = cwd;
    dma_req = dr; dma_we = dwe; dma_addr = AW'(da); dma_wdata = dwd;
    #2;
    eg_d = dr && (m_force || !cr);
    eg_c = cr && !eg_d;
    check("dma_gnt", dma_gnt, eg_d);
    check("cpu_stall", cpu_stall, cr && !eg_c);
    check("mem_en", mem_en, eg_c || eg_d);
    check("mem_addr", mem_addr, eg_c ? ca : eg_d ? da : 8'd0);
    check("mem_we", mem_we, eg_c ? cwe : eg_d ? dwe : 4'd0);
    check("mem_wdata", mem_wdata, eg_c ? cwd : eg_d ? dwd : 32'd0);
    e.own = (eg_c && cwe == 0) ? 2'd1 : (eg_d && dwe == 0) ? 2'd2 : 2'd0;
    e.data = e.own == 1 ? exp_mem[ca] : e.own == 2 ? exp_mem[da] : 32'd0;
    q.push_back(e);
    if (eg_c && cwe != 0) exp_mem[ca] = merge(exp_mem[ca], cwd, cwe);
    if (eg_d && dwe != 0) exp_mem[da] = merge(exp_mem[da], dwd, dwe);
    @(posedge clk);
    #1;
    if (pulse) begin
      rst_n = 0;
      #1 rst_n = 1;
    end
    e = q.pop_front();
    if (pulse) e = '{2'd0, 32'd0};
    check("cpu_rvalid", cpu_rvalid, e.own == 1);
    check("cpu_rdata", cpu_rdata, e.own == 1 ? e.data : 32'd0);
    check("dma_rvalid", dma_rvalid, e.own == 2);
    check("dma_rdata", dma_rdata, e.own == 2 ? e.data : 32'd0);
    if (pulse) begin
      m_force = 0;
      m_cnt = 0;
    end else begin
      m_force = m_force ? !(eg_d || !dr) : (dr && !eg_d && m_cnt == MW - 1);
      m_cnt = (eg_d || !dr) ? 0 : (m_cnt == MW ? MW : m_cnt + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i), 8'h5A, ~8'(i)};
    mem[8'h20] = 32'hDEADBEEF;
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    #1;
    rst_n = 0; cpu_req = 1; cpu_we = 0; cpu_addr = AW'(8'h10);
    #2;
    check("rst_mem_en", mem_en, 1'b1);
    check("rst_mem_addr", mem_addr, 32'h10);
    check("rst_cpu_stall", cpu_stall, 1'b0);
    @(posedge clk);
    #1;
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dma_rvalid", dma_rvalid, 1'b0);
    rst_n = 1;
    step(1, 0, 8'h10, 0, 0, 0, 0, 0);
    step(1, 0, 8'h20, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // contention: CPU holds priority for MW cycles, then one forced DMA grant
    for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h40 + i), 0, 1, 0, 8'h30, 0);
    step(0, 0, 0, 0, 1, 4'b0011, 8'h05, 32'h1234ABCD);
    step(0, 0, 0, 0, 1, 0, 8'h05, 0);
    step(1, 4'hF, 8'h41, 32'hCAFEF00D, 0, 0, 0, 0);
    step(1, 0, 8'h41, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      if (i % 2 == 0) step(1, 0, 8'(8'h50 + i), 0, 0, 0, 0, 0);
      else step(0, 0, 0, 0, 1, 0, 8'(8'h60 + i), 0);
    // dropping dma_req mid-wait restarts the count
    step(1, 0, 8'h11, 0, 1, 0, 8'h31, 0);
    step(1, 0, 8'h12, 0, 1, 0, 8'h31, 0);
    step(1, 0, 8'h13, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h70 + i), 0, 1, 0, 8'h32, 0);
    step(0, 0, 0, 0, 1, 0, 8'h33, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // reset while FORCE is pending must restore CPU priority and clear the count
    step(1, 0, 8'h80, 0, 1, 0, 8'h34, 0);
    step(1, 0, 8'h81, 0, 1, 0, 8'h34, 0);
    step(1, 0, 8'h82, 0, 1, 0, 8'h34, 0);
    step(1, 0, 8'h83, 0, 1, 0, 8'h34, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h90 + i), 0, 1, 0, 8'h34, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
